// File: rtl/conv_pkg.sv
// Shared types and constants for the convolutional-encoder frame sequencer.
package conv_pkg;

  localparam int CONV_K = 7;
  localparam int CONV_M = CONV_K - 1;

  localparam logic [6:0] G0_K7 = 7'o171;
  localparam logic [6:0] G1_K7 = 7'o133;
  localparam logic [8:0] G0_K9 = 9'o753;
  localparam logic [8:0] G1_K9 = 9'o561;

  typedef logic [1:0] sym_t;

  typedef struct packed {
    logic last;
    sym_t sym;
  } fifo_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_DATA,
    ST_TAIL,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/conv_sym_skid2.sv
// Two-entry {last, sym} buffer between the encoder output and the downstream sink.
module conv_sym_skid2
  import conv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  fifo_entry_t push_data,
  input  logic        pop,
  output fifo_entry_t pop_data,
  output logic [1:0]  cnt
);

  fifo_entry_t mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic        do_push;
  logic        do_pop;

  // A push into a full buffer is only taken when a pop frees a slot in the same cycle.
  assign do_pop   = pop && (cnt != 2'd0);
  assign do_push  = push && ((cnt != 2'd2) || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/conv_enc_frame_ctrl.sv
// Frame sequencer for a peer conv_encoder_1_2: seed, payload, optional zero tail,
// with credit flow control so the non-stallable encoder never overruns the symbol buffer.
module conv_enc_frame_ctrl
  import conv_pkg::*;
#(
  parameter int K     = CONV_K,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_term,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  output logic             enc_seed_load,
  output logic [K-2:0]     enc_seed_value,
  output logic             enc_in_valid,
  output logic             enc_in_bit,
  input  logic             enc_out_valid,
  input  logic [1:0]       enc_out_sym,
  output logic             sym_valid,
  output logic [1:0]       sym_data,
  output logic             sym_last,
  input  logic             sym_ready
);

  localparam int M  = K - 1;
  localparam int CW = LEN_W + 1;

  state_t           state;
  state_t           state_nx;
  logic [LEN_W-1:0] len_r;
  logic             term_r;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    total;
  logic             pend;
  logic             pend_last;
  logic [1:0]       fifo_cnt;
  fifo_entry_t      head;
  fifo_entry_t      push_entry;
  logic             push;
  logic             pop;
  logic [2:0]       occ;
  logic             credit_ok;
  logic             last_issue;

  assign total      = {1'b0, len_r} + (term_r ? CW'(M) : '0);
  assign pop        = sym_valid & sym_ready;
  assign push       = enc_out_valid & pend;
  // Symbols in flight plus buffered, less the one leaving now, must leave room for one more.
  assign occ        = {1'b0, fifo_cnt} + {2'b00, pend} - {2'b00, pop};
  assign credit_ok  = occ < 3'd2;
  assign last_issue = (cnt == total - CW'(1));
  assign push_entry = '{last: pend_last, sym: enc_out_sym};

  assign busy           = (state != ST_IDLE);
  assign enc_seed_value = '0;
  assign sym_valid      = (fifo_cnt != 2'd0);
  assign sym_data       = head.sym;
  assign sym_last       = sym_valid & head.last;

  conv_sym_skid2 u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .cnt       (fifo_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      len_r     <= '0;
      term_r    <= 1'b0;
      cnt       <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && start) begin
        len_r  <= cfg_len;
        term_r <= cfg_term;
        cnt    <= '0;
      end else if (enc_in_valid) begin
        cnt <= cnt + CW'(1);
      end
      if (enc_in_valid) begin
        pend      <= 1'b1;
        pend_last <= last_issue;
      end else if (enc_out_valid) begin
        pend      <= 1'b0;
        pend_last <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    enc_seed_load = 1'b0;
    enc_in_valid  = 1'b0;
    enc_in_bit    = 1'b0;
    bit_ready     = 1'b0;
    done          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = (cfg_len == '0 && !cfg_term) ? ST_DRAIN : ST_SEED;
        end
      end
      ST_SEED: begin
        enc_seed_load = 1'b1;
        state_nx      = (len_r != '0) ? ST_DATA : ST_TAIL;
      end
      ST_DATA: begin
        bit_ready    = credit_ok;
        enc_in_valid = bit_valid & credit_ok;
        enc_in_bit   = bit_in;
        if (enc_in_valid && cnt == {1'b0, len_r} - CW'(1)) begin
          state_nx = term_r ? ST_TAIL : ST_DRAIN;
        end
      end
      ST_TAIL: begin
        enc_in_valid = credit_ok;
        if (credit_ok && last_issue) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // An empty frame has no symbol to wait for and completes straight away.
        if (total == '0 || (pop && sym_last)) begin
          done     = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  a_no_orphan_symbol: assert property (@(posedge clk) disable iff (rst) enc_out_valid |-> pend);

endmodule

// File: tb/tb_conv_enc_frame_ctrl.sv
// Directed bench for conv_enc_frame_ctrl with a K=7 171/133 encoder peer model.
module tb_conv_enc_frame_ctrl;
  import conv_pkg::*;

  localparam int LEN_W = 16;
  localparam int M     = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_term;
  logic             start;
  logic             busy;
  logic             done;
  logic             bit_valid;
  logic             bit_in;
  logic             bit_ready;
  logic             enc_seed_load;
  logic [M-1:0]     enc_seed_value;
  logic             enc_in_valid;
  logic             enc_in_bit;
  logic             enc_out_valid;
  logic [1:0]       enc_out_sym;
  logic             sym_valid;
  logic [1:0]       sym_data;
  logic             sym_last;
  logic             sym_ready;

  int total_n = 0;
  int bad_n   = 0;

  logic       payload [128];
  logic [1:0] gold_q [$];
  logic [2:0] rx_q [$];
  int         issued_n = 0;
  int         popped_n = 0;
  int         seed_n   = 0;
  int         done_n   = 0;
  int         viol_n   = 0;

  always #5 clk = ~clk;

  conv_enc_frame_ctrl #(.K(7), .LEN_W(LEN_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_len        (cfg_len),
    .cfg_term       (cfg_term),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .bit_valid      (bit_valid),
    .bit_in         (bit_in),
    .bit_ready      (bit_ready),
    .enc_seed_load  (enc_seed_load),
    .enc_seed_value (enc_seed_value),
    .enc_in_valid   (enc_in_valid),
    .enc_in_bit     (enc_in_bit),
    .enc_out_valid  (enc_out_valid),
    .enc_out_sym    (enc_out_sym),
    .sym_valid      (sym_valid),
    .sym_data       (sym_data),
    .sym_last       (sym_last),
    .sym_ready      (sym_ready)
  );

  function automatic logic [1:0] enc_step(input logic u, input logic [5:0] s);
    logic [6:0] r;
    r = {u, s};
    return {^(r & G0_K7), ^(r & G1_K7)};
  endfunction

  // Encoder peer: shift register with the newest past bit in s[5], symbol one cycle after input.
  logic [5:0] enc_sr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_sr        <= '0;
      enc_out_valid <= 1'b0;
      enc_out_sym   <= 2'b00;
    end else begin
      enc_out_valid <= enc_in_valid;
      if (enc_seed_load) begin
        enc_sr <= enc_seed_value;
      end else if (enc_in_valid) begin
        enc_out_sym <= enc_step(enc_in_bit, enc_sr);
        enc_sr      <= {enc_in_bit, enc_sr[5:1]};
      end
    end
  end

  // Monitor: records popped symbols and flags any credit or handshake rule breach.
  always @(negedge clk) begin
    int occ;
    int pop_now;
    if (rst) begin
      popped_n = issued_n;
    end else begin
      pop_now = (sym_valid && sym_ready) ? 1 : 0;
      occ     = issued_n - popped_n;
      if (occ > 2) viol_n++;
      if ((bit_ready || enc_in_valid) && (occ - pop_now) >= 2) viol_n++;
      if (bit_ready && (enc_in_valid !== bit_valid)) viol_n++;
      if (!busy && (enc_in_valid || bit_ready || enc_seed_load)) viol_n++;
      if (enc_seed_load) seed_n++;
      if (enc_in_valid) issued_n++;
      if (pop_now == 1) begin
        rx_q.push_back({sym_last, sym_data});
        popped_n++;
        if (sym_last && !done) viol_n++;
      end
      if (done) done_n++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_n++;
    assert (observed === expected) else begin
      bad_n++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic void build_golden(input int len, input bit term);
    logic [5:0] s;
    logic       u;
    s = '0;
    gold_q.delete();
    for (int i = 0; i < len + (term ? M : 0); i++) begin
      u = (i < len) ? payload[i] : 1'b0;
      gold_q.push_back(enc_step(u, s));
      s = {u, s[5:1]};
    end
  endfunction

  function automatic void load_hand_1011();
    logic [19:0] hand;
    hand = 20'b11_10_00_10_01_01_00_01_10_11;
    gold_q.delete();
    for (int i = 0; i < 10; i++) gold_q.push_back(hand[19-2*i -: 2]);
    payload[0] = 1'b1; payload[1] = 1'b0; payload[2] = 1'b1; payload[3] = 1'b1;
  endfunction

  function automatic int sym_errs(input int base);
    int e = 0;
    for (int i = 0; i < gold_q.size(); i++) begin
      if (base + i >= rx_q.size()) e++;
      else if (rx_q[base+i][1:0] !== gold_q[i]) e++;
    end
    return e;
  endfunction

  function automatic int last_errs(input int base);
    int e = 0;
    for (int i = base; i < rx_q.size(); i++) begin
      if (rx_q[i][2] !== ((i == base + gold_q.size() - 1) ? 1'b1 : 1'b0)) e++;
    end
    return e;
  endfunction

  task automatic applyStimulus(input int len, input bit term, input bit gaps, input bit rnd_ready,
                               input int start_at, input int abort_at,
                               output bit done_seen, output int done_lat);
    int idx;
    bit hs;
    idx       = 0;
    done_seen = 1'b0;
    done_lat  = 0;
    cfg_len   = LEN_W'(len);
    cfg_term  = term;
    start     = 1'b1;
    sym_ready = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    cfg_len  = '1;
    cfg_term = ~term;
    for (int cyc = 0; cyc < 2000 && !done_seen; cyc++) begin
      if (abort_at >= 0 && idx == abort_at) begin
        rst = 1'b1;
        #1;
        checkOutput("abort_outs", 32'({busy, done, bit_ready, enc_seed_load, enc_in_valid, enc_in_bit,
                                      sym_valid, sym_data, sym_last}), 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst       = 1'b0;
        bit_valid = 1'b0;
        return;
      end
      bit_valid = (idx < len) && !(gaps && (cyc % 3 == 1));
      bit_in    = (idx < len) ? payload[idx] : 1'b0;
      sym_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = (cyc == start_at);
      @(negedge clk);
      hs = bit_valid && bit_ready;
      if (done) begin
        done_seen = 1'b1;
        done_lat  = cyc + 1;
      end
      @(posedge clk); #1;
      if (hs) idx++;
    end
    bit_valid = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    bit dseen;
    int dlat, rb, sb, db;
    rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_term = 1'b0;
    bit_valid = 1'b0; bit_in = 1'b0; sym_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    checkOutput("reset_outs", 32'({busy, done, bit_ready, enc_seed_load, enc_in_valid, enc_in_bit,
                                  sym_valid, sym_data, sym_last, enc_seed_value}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] frame len=4 term=1 bits 1011");
    load_hand_1011();
    rb = rx_q.size(); sb = seed_n; db = done_n;
    applyStimulus(4, 1'b1, 1'b0, 1'b0, -1, -1, dseen, dlat);
    checkOutput("t1_done_seen", 32'(dseen), 32'd1);
    checkOutput("t1_done_lat", 32'(dlat), 32'd13);
    checkOutput("t1_count", 32'(rx_q.size() - rb), 32'd10);
    checkOutput("t1_syms", 32'(sym_errs(rb)), 32'd0);
    checkOutput("t1_last", 32'(last_errs(rb)), 32'd0);
    checkOutput("t1_seed", 32'(seed_n - sb), 32'd1);
    checkOutput("t1_done_cnt", 32'(done_n - db), 32'd1);

    $display("[TB] frame len=64 random bits, random sym_ready");
    for (int i = 0; i < 64; i++) payload[i] = 1'($urandom_range(0, 1));
    build_golden(64, 1'b1);
    rb = rx_q.size(); sb = seed_n; db = done_n;
    applyStimulus(64, 1'b1, 1'b0, 1'b1, -1, -1, dseen, dlat);
    checkOutput("t2_done_seen", 32'(dseen), 32'd1);
    checkOutput("t2_count", 32'(rx_q.size() - rb), 32'd70);
    checkOutput("t2_syms", 32'(sym_errs(rb)), 32'd0);
    checkOutput("t2_last", 32'(last_errs(rb)), 32'd0);
    checkOutput("t2_seed", 32'(seed_n - sb), 32'd1);
    checkOutput("t2_done_cnt", 32'(done_n - db), 32'd1);

    $display("[TB] frame len=16 term=0 with bit_valid gaps");
    for (int i = 0; i < 16; i++) payload[i] = 1'((i * 5 + 3) % 7 > 3);
    build_golden(16, 1'b0);
    rb = rx_q.size();
    applyStimulus(16, 1'b0, 1'b1, 1'b0, -1, -1, dseen, dlat);
    checkOutput("t3_done_seen", 32'(dseen), 32'd1);
    checkOutput("t3_count", 32'(rx_q.size() - rb), 32'd16);
    checkOutput("t3_syms", 32'(sym_errs(rb)), 32'd0);
    checkOutput("t3_last", 32'(last_errs(rb)), 32'd0);

    $display("[TB] empty frames");
    rb = rx_q.size(); sb = seed_n;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, -1, -1, dseen, dlat);
    checkOutput("t4_done_lat", 32'(dlat), 32'd1);
    checkOutput("t4_count", 32'(rx_q.size() - rb), 32'd0);
    checkOutput("t4_seed", 32'(seed_n - sb), 32'd0);
    gold_q.delete();
    for (int i = 0; i < 6; i++) gold_q.push_back(2'b00);
    rb = rx_q.size(); sb = seed_n;
    applyStimulus(0, 1'b1, 1'b0, 1'b0, -1, -1, dseen, dlat);
    checkOutput("t5_done_seen", 32'(dseen), 32'd1);
    checkOutput("t5_count", 32'(rx_q.size() - rb), 32'd6);
    checkOutput("t5_syms", 32'(sym_errs(rb)), 32'd0);
    checkOutput("t5_last", 32'(last_errs(rb)), 32'd0);
    checkOutput("t5_seed", 32'(seed_n - sb), 32'd1);

    $display("[TB] start during DATA, then back-to-back frame");
    for (int i = 0; i < 8; i++) payload[i] = 1'(i % 3 == 0);
    build_golden(8, 1'b1);
    rb = rx_q.size(); db = done_n;
    applyStimulus(8, 1'b1, 1'b0, 1'b0, 3, -1, dseen, dlat);
    checkOutput("t6_count", 32'(rx_q.size() - rb), 32'd14);
    checkOutput("t6_syms", 32'(sym_errs(rb)), 32'd0);
    checkOutput("t6_done_cnt", 32'(done_n - db), 32'd1);
    for (int i = 0; i < 5; i++) payload[i] = 1'(i != 2);
    build_golden(5, 1'b1);
    rb = rx_q.size(); sb = seed_n;
    applyStimulus(5, 1'b1, 1'b0, 1'b0, -1, -1, dseen, dlat);
    checkOutput("t7_done_seen", 32'(dseen), 32'd1);
    checkOutput("t7_seed", 32'(seed_n - sb), 32'd1);
    checkOutput("t7_syms", 32'(sym_errs(rb)), 32'd0);
    checkOutput("t7_last", 32'(last_errs(rb)), 32'd0);

    $display("[TB] reset mid-DATA, then fresh frame");
    for (int i = 0; i < 32; i++) payload[i] = 1'b1;
    db = done_n;
    applyStimulus(32, 1'b1, 1'b0, 1'b0, -1, 10, dseen, dlat);
    checkOutput("t8_no_done", 32'(done_n - db), 32'd0);
    checkOutput("t8_idle", 32'(busy), 32'd0);
    load_hand_1011();
    rb = rx_q.size();
    applyStimulus(4, 1'b1, 1'b0, 1'b0, -1, -1, dseen, dlat);
    checkOutput("t9_done_lat", 32'(dlat), 32'd13);
    checkOutput("t9_count", 32'(rx_q.size() - rb), 32'd10);
    checkOutput("t9_syms", 32'(sym_errs(rb)), 32'd0);
    checkOutput("t9_last", 32'(last_errs(rb)), 32'd0);

    checkOutput("credit_and_handshake_rules", 32'(viol_n), 32'd0);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
